// File: rtl/typer_round_controller.sv
// Game sequencer for the speed-typer word datapath: loads words, checks keys, counts errors.
// Define ROUND_TIMER_EN to add the per-word time limit; otherwise timeout is tied low.
module typer_round_controller #(
    parameter int          NUM_LEVELS   = 30,
    parameter int          LOAD_WAIT    = 3,
    parameter int          MAX_ERRORS   = 15,
    parameter logic [31:0] TIMER_CYCLES = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic [7:0] comparison_data,
    input  logic [7:0] num_char,
    output logic       enable_next_level,
    output logic       get_next_character,
    output logic [7:0] level,
    output logic [7:0] char_index,
    output logic [7:0] error_count,
    output logic       busy,
    output logic       round_done,
    output logic       game_done,
    output logic       game_fail,
    output logic       timeout
);

    localparam int              LW         = (LOAD_WAIT < 2) ? 1 : $clog2(LOAD_WAIT + 1);
    localparam logic [LW-1:0]   LOAD_INIT  = LW'(LOAD_WAIT);
    localparam logic [7:0]      LAST_LEVEL = 8'(NUM_LEVELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        LOAD,
        TYPE,
        ADVANCE,
        LEVEL_DONE,
        DONE,
        FAIL
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [LW-1:0]   load_cnt;
    logic [LW-1:0]   load_cnt_nxt;
    logic [7:0]      level_nxt;
    logic [7:0]      char_nxt;
    logic [7:0]      err_nxt;
    logic [7:0]      char_inc;
    logic            key_hit;
    logic            timer_expired;
    logic            timer_load;
    logic            timeout_set;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic err_limit_hit(input logic [7:0] cnt);
        return (MAX_ERRORS != 0) && (int'({24'd0, cnt}) >= MAX_ERRORS);
    endfunction

    assign char_inc = char_index + 8'd1;
    assign key_hit  = key_valid && (key_code == comparison_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        load_cnt_nxt = load_cnt;
        level_nxt    = level;
        char_nxt     = char_index;
        err_nxt      = error_count;
        timer_load   = 1'b0;
        timeout_set  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = PRIME;
                end
            end
            PRIME: begin
                state_nxt    = LOAD;
                load_cnt_nxt = LOAD_INIT;
            end
            LOAD: begin
                // Leaving on the edge where the count reaches zero keeps LOAD exactly LOAD_WAIT cycles long.
                if (load_cnt <= LW'(1)) begin
                    state_nxt    = TYPE;
                    load_cnt_nxt = '0;
                    char_nxt     = 8'd0;
                    timer_load   = 1'b1;
                end else begin
                    load_cnt_nxt = load_cnt - LW'(1);
                end
            end
            TYPE: begin
                if (key_hit) begin
                    char_nxt  = char_inc;
                    state_nxt = (char_inc == num_char) ? LEVEL_DONE : ADVANCE;
                end else if (timer_expired) begin
                    state_nxt   = FAIL;
                    timeout_set = 1'b1;
                end else if (key_valid) begin
                    err_nxt = sat_inc8(error_count);
                    if (err_limit_hit(err_nxt)) begin
                        state_nxt = FAIL;
                    end
                end
            end
            ADVANCE: begin
                state_nxt = TYPE;
            end
            LEVEL_DONE: begin
                if (level == LAST_LEVEL) begin
                    state_nxt = DONE;
                end else begin
                    level_nxt = level + 8'd1;
                    state_nxt = PRIME;
                end
            end
            DONE, FAIL: begin
                state_nxt = state;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs follow the state being entered so every pulse lines up with its state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_cnt           <= '0;
            level              <= 8'd0;
            char_index         <= 8'd0;
            error_count        <= 8'd0;
            enable_next_level  <= 1'b0;
            get_next_character <= 1'b0;
            busy               <= 1'b0;
            round_done         <= 1'b0;
            game_done          <= 1'b0;
            game_fail          <= 1'b0;
        end else begin
            load_cnt           <= load_cnt_nxt;
            level              <= level_nxt;
            char_index         <= char_nxt;
            error_count        <= err_nxt;
            enable_next_level  <= (state_nxt == PRIME);
            get_next_character <= (state_nxt == ADVANCE);
            busy               <= !(state_nxt inside {IDLE, DONE, FAIL});
            round_done         <= (state_nxt == LEVEL_DONE);
            game_done          <= (state_nxt == DONE);
            game_fail          <= (state_nxt == FAIL);
        end
    end

`ifdef ROUND_TIMER_EN
    logic [31:0] timer_cnt;
    logic        timeout_r;

    assign timer_expired = (timer_cnt == 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_cnt <= 32'd0;
            timeout_r <= 1'b0;
        end else begin
            if (timer_load) begin
                timer_cnt <= TIMER_CYCLES;
            end else if ((state == TYPE || state == ADVANCE) && !timer_expired) begin
                timer_cnt <= timer_cnt - 32'd1;
            end
            if (timeout_set) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign timeout = timeout_r;
`else
    logic unused_timer;

    assign unused_timer  = (^TIMER_CYCLES) ^ timer_load ^ timeout_set;
    assign timer_expired = 1'b0;
    assign timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_typer_round_controller.sv
// Directed bench for typer_round_controller: per-cycle vector table plus fail, reset and timer sequences.
module tb_typer_round_controller;

    logic       clk;
    logic       reset;
    logic       start;
    logic       key_valid;
    logic [7:0] key_code;
    logic [7:0] comparison_data;
    logic [7:0] num_char;
    logic       enable_next_level;
    logic       get_next_character;
    logic [7:0] level;
    logic [7:0] char_index;
    logic [7:0] error_count;
    logic       busy;
    logic       round_done;
    logic       game_done;
    logic       game_fail;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typer_round_controller #(
        .NUM_LEVELS  (2),
        .LOAD_WAIT   (3),
        .MAX_ERRORS  (3),
        .TIMER_CYCLES(32'd100)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .key_valid         (key_valid),
        .key_code          (key_code),
        .comparison_data   (comparison_data),
        .num_char          (num_char),
        .enable_next_level (enable_next_level),
        .get_next_character(get_next_character),
        .level             (level),
        .char_index        (char_index),
        .error_count       (error_count),
        .busy              (busy),
        .round_done        (round_done),
        .game_done         (game_done),
        .game_fail         (game_fail),
        .timeout           (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       kv;
        logic [7:0] kc;
        logic [7:0] cd;
        logic [7:0] nc;
        logic       en;
        logic       get;
        logic [7:0] lvl;
        logic [7:0] ci;
        logic [7:0] err;
        logic       bsy;
        logic       rd;
        logic       gd;
        logic       gf;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic st, input logic kv, input logic [7:0] kc,
                                input logic [7:0] cd, input logic [7:0] nc,
                                input logic en, input logic get, input logic [7:0] lvl,
                                input logic [7:0] ci, input logic [7:0] err, input logic bsy,
                                input logic rd, input logic gd, input logic gf);
        vec_t v;
        v.st = st; v.kv = kv; v.kc = kc; v.cd = cd; v.nc = nc;
        v.en = en; v.get = get; v.lvl = lvl; v.ci = ci; v.err = err;
        v.bsy = bsy; v.rd = rd; v.gd = gd; v.gf = gf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Start a game and run until the controller has just entered TYPE.
    task automatic start_to_type();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
    endtask

    task automatic key(input logic [7:0] code, input logic [7:0] expect_code);
        key_valid       = 1'b1;
        key_code        = code;
        comparison_data = expect_code;
        tick();
        idle_inputs();
    endtask

    initial begin
        int en_cnt;
        int waited;

        reset           = 1'b1;
        comparison_data = 8'h00;
        num_char        = 8'd3;
        idle_inputs();

        //         st kv kc     cd     nc    en get lvl ci err bsy rd gd gf
        vecs[0]  = mk(1, 0, 8'h00, 8'h24, 8'd3, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 8'h00, 8'h24, 8'd3, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[2]  = mk(0, 1, 8'h1C, 8'h24, 8'd3, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 8'h00, 8'h24, 8'd3, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[4]  = mk(0, 1, 8'h1C, 8'h24, 8'd3, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[5]  = mk(0, 1, 8'h1C, 8'h24, 8'd3, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        vecs[6]  = mk(0, 1, 8'h24, 8'h24, 8'd3, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        vecs[7]  = mk(0, 1, 8'h21, 8'h21, 8'd3, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        vecs[8]  = mk(0, 1, 8'h21, 8'h21, 8'd3, 0, 1, 0, 2, 1, 1, 0, 0, 0);
        vecs[9]  = mk(1, 0, 8'h00, 8'h2B, 8'd3, 0, 0, 0, 2, 1, 1, 0, 0, 0);
        vecs[10] = mk(0, 1, 8'h2B, 8'h2B, 8'd3, 0, 0, 0, 3, 1, 1, 1, 0, 0);
        vecs[11] = mk(0, 0, 8'h00, 8'h1C, 8'd2, 1, 0, 1, 3, 1, 1, 0, 0, 0);
        vecs[12] = mk(0, 0, 8'h00, 8'h1C, 8'd2, 0, 0, 1, 3, 1, 1, 0, 0, 0);
        vecs[13] = mk(0, 0, 8'h00, 8'h1C, 8'd2, 0, 0, 1, 3, 1, 1, 0, 0, 0);
        vecs[14] = mk(0, 0, 8'h00, 8'h1C, 8'd2, 0, 0, 1, 3, 1, 1, 0, 0, 0);
        vecs[15] = mk(0, 0, 8'h00, 8'h1C, 8'd2, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        vecs[16] = mk(0, 1, 8'h1C, 8'h1C, 8'd2, 0, 1, 1, 1, 1, 1, 0, 0, 0);
        vecs[17] = mk(0, 0, 8'h00, 8'h32, 8'd2, 0, 0, 1, 1, 1, 1, 0, 0, 0);
        vecs[18] = mk(0, 1, 8'h32, 8'h32, 8'd2, 0, 0, 1, 2, 1, 1, 1, 0, 0);
        vecs[19] = mk(0, 0, 8'h00, 8'h32, 8'd2, 0, 0, 1, 2, 1, 0, 0, 1, 0);
        vecs[20] = mk(1, 1, 8'h1C, 8'h1C, 8'd2, 0, 0, 1, 2, 1, 0, 0, 1, 0);

        do_reset();
        chk("reset_outputs",
            {enable_next_level, get_next_character, level, char_index, error_count,
             busy, round_done, game_done, game_fail, timeout}, 32'd0);

        // Full two-word game, one table row per clock.
        en_cnt = 0;
        for (int i = 0; i < 21; i++) begin
            start           = vecs[i].st;
            key_valid       = vecs[i].kv;
            key_code        = vecs[i].kc;
            comparison_data = vecs[i].cd;
            num_char        = vecs[i].nc;
            tick();
            idle_inputs();
            if (enable_next_level) en_cnt++;
            chk($sformatf("row%0d_enable", i), enable_next_level, vecs[i].en);
            chk($sformatf("row%0d_get", i), get_next_character, vecs[i].get);
            chk($sformatf("row%0d_level", i), level, vecs[i].lvl);
            chk($sformatf("row%0d_char_index", i), char_index, vecs[i].ci);
            chk($sformatf("row%0d_error_count", i), error_count, vecs[i].err);
            chk($sformatf("row%0d_busy", i), busy, vecs[i].bsy);
            chk($sformatf("row%0d_round_done", i), round_done, vecs[i].rd);
            chk($sformatf("row%0d_game_done", i), game_done, vecs[i].gd);
            chk($sformatf("row%0d_game_fail", i), game_fail, vecs[i].gf);
        end
        chk("enable_pulse_total", en_cnt, 2);

        // Error limit: three mismatches fail the game, then everything freezes.
        do_reset();
        num_char = 8'd3;
        start_to_type();
        key(8'h1C, 8'h24);
        chk("fail_err1", error_count, 8'd1);
        chk("fail_busy_after_err1", busy, 1'b1);
        key(8'h1B, 8'h24);
        chk("fail_err2", error_count, 8'd2);
        chk("fail_not_yet", game_fail, 1'b0);
        key(8'h1D, 8'h24);
        chk("fail_err3", error_count, 8'd3);
        chk("fail_game_fail", game_fail, 1'b1);
        chk("fail_busy_low", busy, 1'b0);
        chk("fail_no_timeout", timeout, 1'b0);
        start = 1'b1;
        key(8'h24, 8'h24);
        key(8'h15, 8'h24);
        tick();
        chk("fail_frozen_err", error_count, 8'd3);
        chk("fail_frozen_ci", char_index, 8'd0);
        chk("fail_held", {game_fail, busy, enable_next_level, game_done}, 4'b1000);

        // Asynchronous reset in the middle of TYPE, checked before any clock edge.
        do_reset();
        num_char = 8'd3;
        start_to_type();
        key(8'h24, 8'h24);
        chk("pre_reset_ci", char_index, 8'd1);
        chk("pre_reset_get", get_next_character, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs",
            {enable_next_level, get_next_character, level, char_index, error_count,
             busy, round_done, game_done, game_fail, timeout}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

`ifdef ROUND_TIMER_EN
        // No keys: the per-word timer must expire and fail the game.
        start_to_type();
        waited = 0;
        while (!game_fail && waited < 400) begin
            tick();
            waited++;
        end
        chk("timer_fail_within_bound", (waited < 400), 1'b1);
        chk("timer_timeout", timeout, 1'b1);
        chk("timer_game_fail", game_fail, 1'b1);
        chk("timer_busy_low", busy, 1'b0);
`else
        // Without the timer a silent player waits forever.
        start_to_type();
        waited = 0;
        while (waited < 150) begin
            tick();
            waited++;
        end
        chk("notimer_timeout", timeout, 1'b0);
        chk("notimer_no_fail", game_fail, 1'b0);
        chk("notimer_busy", busy, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
